// File: rtl/line_ring_scanout.sv
// Line ring buffer between a pixel producer and an LCD scanout path.
// The producer fills whole lines into NUM_LINES slots; the panel reads one slot per de_in pulse.
module line_ring_scanout #(
    parameter int               H_RES      = 800,
    parameter int               PIX_W      = 24,
    parameter int               NUM_LINES  = 4,
    parameter logic [PIX_W-1:0] FILL_COLOR = '0
) (
    input  logic                             clk_pixel,
    input  logic                             rst_n,
    input  logic                             wr_valid,
    output logic                             wr_ready,
    input  logic [PIX_W-1:0]                 wr_data,
    input  logic                             wr_last,
    input  logic                             de_in,
    input  logic                             vsync_in,
    output logic [PIX_W-1:0]                 rd_data,
    output logic                             de_out,
    output logic                             line_request,
    output logic [$clog2(NUM_LINES+1)-1:0]   lines_ready,
    output logic                             underrun,
    output logic                             len_err
);

    localparam int SW    = $clog2(NUM_LINES);
    localparam int XW    = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int RXW   = $clog2(H_RES + 1);
    localparam int DEPTH = NUM_LINES * H_RES;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LRW   = $clog2(NUM_LINES + 1);

    function automatic logic [SW-1:0] next_slot(input logic [SW-1:0] s);
        return (s == SW'(NUM_LINES - 1)) ? '0 : s + SW'(1);
    endfunction

    logic [PIX_W-1:0] mem [DEPTH];

    logic             ready_en;
    logic             vsync_d;
    logic [SW-1:0]    wr_slot;
    logic [SW-1:0]    rd_slot;
    logic [XW-1:0]    wr_addr;
    logic [RXW-1:0]   rd_x;
    logic             rd_live;
    logic [LRW-1:0]   flush_left;
    logic             rel_p1;
    logic             vld_p1;
    logic [PIX_W-1:0] pix_p1;

    logic             flush;
    logic             wr_fire;
    logic             wr_term;
    logic             commit;
    logic             short_line;
    logic             de_rise;
    logic             de_fall;
    logic             live_now;
    logic             release_slot;
    logic [RXW-1:0]   rd_x_cur;
    logic             vld_p0;
    logic [AW-1:0]    waddr;
    logic [AW-1:0]    raddr;

    // Stage p0: input-cycle decode of producer, timing and frame events
    assign flush        = vsync_in & ~vsync_d;
    assign wr_ready     = ready_en && (lines_ready < LRW'(NUM_LINES)) && !flush;
    assign wr_fire      = wr_valid & wr_ready;
    assign wr_term      = (wr_addr == XW'(H_RES - 1)) | wr_last;
    assign commit       = wr_fire & wr_term;
    assign short_line   = wr_fire & wr_last & (wr_addr != XW'(H_RES - 1));
    assign de_rise      = de_in & ~de_out;
    assign de_fall      = ~de_in & de_out;
    assign live_now     = de_rise ? (lines_ready != '0) : rd_live;
    assign release_slot = de_fall & rd_live & ~flush;
    assign rd_x_cur     = de_rise ? '0 : rd_x;
    assign vld_p0       = de_in & live_now & ~flush & (rd_x_cur < RXW'(H_RES));
    assign waddr        = AW'(int'(wr_slot) * H_RES + int'(wr_addr));
    assign raddr        = vld_p0 ? AW'(int'(rd_slot) * H_RES + int'(rd_x_cur)) : '0;

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            ready_en    <= 1'b0;
            vsync_d     <= 1'b0;
            de_out      <= 1'b0;
            vld_p1      <= 1'b0;
            underrun    <= 1'b0;
            len_err     <= 1'b0;
            rel_p1      <= 1'b0;
            flush_left  <= '0;
            lines_ready <= '0;
            wr_slot     <= '0;
            rd_slot     <= '0;
            wr_addr     <= '0;
            rd_x        <= '0;
            rd_live     <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            vsync_d  <= vsync_in;
            de_out   <= de_in;
            vld_p1   <= vld_p0;
            underrun <= de_rise & (lines_ready == '0);
            len_err  <= short_line;
            rel_p1   <= release_slot;
            if (de_in)
                rd_x <= (rd_x_cur == RXW'(H_RES)) ? rd_x_cur : rd_x_cur + RXW'(1);
            if (flush) begin
                // Drop everything queued and announce every slot as free.
                lines_ready <= '0;
                wr_slot     <= '0;
                rd_slot     <= '0;
                wr_addr     <= '0;
                rd_live     <= 1'b0;
                flush_left  <= LRW'(NUM_LINES);
            end else begin
                if (flush_left != '0)
                    flush_left <= flush_left - LRW'(1);
                if (wr_fire)
                    wr_addr <= wr_term ? '0 : wr_addr + XW'(1);
                if (commit)
                    wr_slot <= next_slot(wr_slot);
                if (release_slot)
                    rd_slot <= next_slot(rd_slot);
                case ({commit, release_slot})
                    2'b10:   lines_ready <= lines_ready + LRW'(1);
                    2'b01:   lines_ready <= lines_ready - LRW'(1);
                    default: lines_ready <= lines_ready;
                endcase
                if (de_rise)
                    rd_live <= (lines_ready != '0);
                else if (de_fall)
                    rd_live <= 1'b0;
            end
        end
    end

    // Stage p1: synchronous RAM read, aligned with de_out
    always_ff @(posedge clk_pixel) begin
        if (wr_fire)
            mem[waddr] <= wr_data;
        pix_p1 <= mem[raddr];
    end

    assign rd_data      = vld_p1 ? pix_p1 : FILL_COLOR;
    assign line_request = rel_p1 | (flush_left != '0);

endmodule

// File: tb/tb_line_ring_scanout.sv
// Scoreboard bench for line_ring_scanout: expected pixels are queued by the stimulus
// and popped by a negedge monitor whenever de_out is high.
module tb_line_ring_scanout;

    localparam int               H_RES     = 8;
    localparam int               PIX_W     = 24;
    localparam int               NUM_LINES = 4;
    localparam logic [PIX_W-1:0] FILL      = 24'hABCDEF;

    logic             clk_pixel = 1'b0;
    logic             rst_n;
    logic             wr_valid;
    logic             wr_ready;
    logic [PIX_W-1:0] wr_data;
    logic             wr_last;
    logic             de_in;
    logic             vsync_in;
    logic [PIX_W-1:0] rd_data;
    logic             de_out;
    logic             line_request;
    logic [2:0]       lines_ready;
    logic             underrun;
    logic             len_err;

    int total = 0;
    int bad   = 0;
    int n_req = 0;
    int n_und = 0;
    int n_len = 0;
    logic [PIX_W-1:0] exp_q [$];

    line_ring_scanout #(
        .H_RES(H_RES), .PIX_W(PIX_W), .NUM_LINES(NUM_LINES), .FILL_COLOR(FILL)
    ) dut (
        .clk_pixel(clk_pixel), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_last(wr_last),
        .de_in(de_in), .vsync_in(vsync_in),
        .rd_data(rd_data), .de_out(de_out), .line_request(line_request),
        .lines_ready(lines_ready), .underrun(underrun), .len_err(len_err)
    );

    always #5 clk_pixel = ~clk_pixel;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pixel scoreboard, idle fill check and pulse counters.
    always @(negedge clk_pixel) begin
        if (line_request === 1'b1) n_req++;
        if (underrun === 1'b1) n_und++;
        if (len_err === 1'b1) n_len++;
        if (de_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_empty: got pixel %h expected none at %0t", rd_data, $time);
            end else begin
                check("pixel", 32'(rd_data), 32'(exp_q.pop_front()));
            end
        end else begin
            check("idle_fill", 32'(rd_data), 32'(FILL));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic write_line(input logic [PIX_W-1:0] base, input int n, input bit last);
        for (int x = 0; x < n; x++) begin
            wr_valid = 1'b1;
            wr_data  = base + PIX_W'(x);
            wr_last  = last && (x == n - 1);
            check("wr_ready_write", 32'(wr_ready), 32'd1);
            tick();
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic push_seq(input logic [PIX_W-1:0] base, input int n);
        for (int x = 0; x < n; x++) exp_q.push_back(base + PIX_W'(x));
    endtask

    task automatic push_fill(input int n);
        for (int x = 0; x < n; x++) exp_q.push_back(FILL);
    endtask

    task automatic scan(input int n);
        for (int i = 0; i < n; i++) begin
            de_in = 1'b1;
            tick();
        end
        de_in = 1'b0;
        repeat (3) tick();
    endtask

    int r0, u0, l0;

    initial begin
        rst_n = 1'b1; wr_valid = 1'b0; wr_data = '0; wr_last = 1'b0;
        de_in = 1'b0; vsync_in = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) tick();
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_de_out", 32'(de_out), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'(FILL));
        check("rst_lines_ready", 32'(lines_ready), 32'd0);
        check("rst_line_request", 32'(line_request), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_len_err", 32'(len_err), 32'd0);
        rst_n = 1'b1;
        #1 check("ready_before_edge", 32'(wr_ready), 32'd0);
        tick();
        check("ready_after_edge", 32'(wr_ready), 32'd1);

        // Prefill four full lines, value = line*16 + x
        r0 = n_req; u0 = n_und; l0 = n_len;
        for (int l = 0; l < NUM_LINES; l++) write_line(PIX_W'(l * 16), H_RES, 1'b0);
        check("prefill_lines", 32'(lines_ready), 32'd4);
        check("prefill_ready", 32'(wr_ready), 32'd0);
        wr_valid = 1'b1; wr_data = 24'h0000EE;
        repeat (3) begin
            check("full_ready", 32'(wr_ready), 32'd0);
            tick();
        end
        wr_valid = 1'b0;
        check("prefill_len_err", 32'(n_len - l0), 32'd0);
        push_seq(24'h00, H_RES);
        scan(H_RES);
        check("scan0_lines", 32'(lines_ready), 32'd3);
        check("scan0_req", 32'(n_req - r0), 32'd1);
        check("scan0_underrun", 32'(n_und - u0), 32'd0);
        push_seq(24'h10, H_RES);
        scan(H_RES);
        check("scan1_lines", 32'(lines_ready), 32'd2);

        // Commit into slot 0 in the same cycle de_in falls on slot 2
        r0 = n_req;
        push_seq(24'h20, H_RES);
        for (int c = 0; c <= H_RES; c++) begin
            de_in    = (c < H_RES);
            wr_valid = (c >= 1);
            wr_data  = 24'h40 + PIX_W'(c - 1);
            tick();
        end
        wr_valid = 1'b0; de_in = 1'b0;
        check("simul_lines", 32'(lines_ready), 32'd2);
        repeat (3) tick();
        check("simul_req", 32'(n_req - r0), 32'd1);
        push_seq(24'h30, H_RES);
        scan(H_RES);
        push_seq(24'h40, H_RES);
        scan(H_RES);
        check("drain_lines", 32'(lines_ready), 32'd0);

        // Underrun on an empty ring
        r0 = n_req; u0 = n_und;
        push_fill(H_RES);
        scan(H_RES);
        check("under_pulse", 32'(n_und - u0), 32'd1);
        check("under_req", 32'(n_req - r0), 32'd0);
        check("under_lines", 32'(lines_ready), 32'd0);

        // de_in held past H_RES pixels
        write_line(24'h50, H_RES, 1'b0);
        push_seq(24'h50, H_RES);
        push_fill(2);
        scan(H_RES + 2);
        check("long_lines", 32'(lines_ready), 32'd0);

        // Short line: wr_last on the 5th pixel; tail keeps the old slot-2 data
        l0 = n_len;
        write_line(24'h60, 5, 1'b1);
        tick();
        check("short_len_err", 32'(n_len - l0), 32'd1);
        check("short_lines", 32'(lines_ready), 32'd1);
        write_line(24'h70, H_RES, 1'b0);
        check("short_next_lines", 32'(lines_ready), 32'd2);
        push_seq(24'h60, 5);
        push_seq(24'h25, 3);
        scan(H_RES);
        push_seq(24'h70, H_RES);
        scan(H_RES);

        // Flush with rd_slot=2, wr_slot=1, lines_ready=3, wr_addr=3
        write_line(24'h80, H_RES, 1'b0);
        write_line(24'h88, H_RES, 1'b0);
        push_seq(24'h80, H_RES);
        scan(H_RES);
        push_seq(24'h88, H_RES);
        scan(H_RES);
        write_line(24'h90, H_RES, 1'b0);
        write_line(24'hA0, H_RES, 1'b0);
        write_line(24'hC0, H_RES, 1'b0);
        write_line(24'hB0, 3, 1'b0);
        check("preflush_lines", 32'(lines_ready), 32'd3);
        r0 = n_req;
        vsync_in = 1'b1; wr_valid = 1'b1; wr_data = 24'h0000CC;
        #1 check("flush_ready", 32'(wr_ready), 32'd0);
        tick();
        wr_valid = 1'b0;
        check("flush_lines", 32'(lines_ready), 32'd0);
        repeat (7) tick();
        vsync_in = 1'b0;
        check("flush_req", 32'(n_req - r0), 32'd4);
        write_line(24'hD0, H_RES, 1'b0);
        push_seq(24'hD0, H_RES);
        scan(H_RES);

        // vsync during an active line
        write_line(24'hE0, H_RES, 1'b0);
        r0 = n_req; u0 = n_und;
        push_seq(24'hE0, 3);
        push_fill(H_RES - 3);
        for (int i = 0; i < H_RES; i++) begin
            de_in    = 1'b1;
            vsync_in = (i >= 3);
            tick();
        end
        de_in = 1'b0;
        repeat (3) tick();
        vsync_in = 1'b0;
        check("midline_lines", 32'(lines_ready), 32'd0);
        check("midline_req", 32'(n_req - r0), 32'd4);
        check("midline_underrun", 32'(n_und - u0), 32'd0);
        tick();

        // Reset in the middle of a line
        write_line(24'hF0, H_RES, 1'b0);
        push_seq(24'hF0, 2);
        for (int i = 0; i < 3; i++) begin
            de_in = 1'b1;
            tick();
        end
        rst_n = 1'b0;
        #1;
        check("midrst_de_out", 32'(de_out), 32'd0);
        check("midrst_rd_data", 32'(rd_data), 32'(FILL));
        check("midrst_ready", 32'(wr_ready), 32'd0);
        repeat (2) tick();
        de_in = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("postrst_ready", 32'(wr_ready), 32'd1);
        check("postrst_lines", 32'(lines_ready), 32'd0);
        repeat (2) tick();
        check("sb_leftover", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
